// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the time-multiplexed slice adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   SLICE_W   default adder slice width
//   state_t   sequencer FSM states
//   nslice()  number of slices for a given operand width
//   clog2w()  index width, never below 1 bit
package add_seq_pkg;

    localparam int SLICE_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nslice(input int data_w, input int slice_w);
        return data_w / slice_w;
    endfunction

    // Width of an index into n items; a single item still needs one bit.
    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_slice_sequencer_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after last_grant, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is used.
//
// Ports:
//   req         request vector, one bit per requester
//   last_grant  index of the most recently served requester
//   grant       one-hot grant (all zero when nothing requests)
//   grant_idx   binary index of the granted requester
//   grant_vld   high when any requester is granted
module rr_arbiter
    import add_seq_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = clog2w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx,
    output logic             grant_vld
);

    // Walk the ring starting one past the last winner; the last candidate
    // visited is last_grant itself, so a lone repeat requester still wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            int cand;
            cand = (int'(last_grant) + off) % N_REQ;
            if (!grant_vld && req[cand]) begin
                grant_vld   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/add_slice_sequencer.sv
// Shares one SLICE_W-bit adder slice among N_REQ requesters, summing LSB-first.
// Latency: accept in cycle T gives res_valid in cycle T+NSLICE+1.
// Backpressure: result held in DONE until res_ready; no new accept until then.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready  per-requester request and one-hot accept
//   req_a, req_b         packed operands, requester i at [i*DATA_W +: DATA_W]
//   res_valid/res_ready  result handshake
//   res_sum, res_cout    sum and carry out of the MSB slice
//   res_id               requester that owns the result
//   busy                 high while an operation is in RUN or DONE
//
// Build option: define ADD_SEQ_SATURATE_EN to clamp res_sum to all ones when
// the final carry is set (res_cout still reports the carry).
module add_slice_sequencer
    import add_seq_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 12,
    parameter int SLICE_W = add_seq_pkg::SLICE_W,
    parameter int IDW     = clog2w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_W-1:0]       res_sum,
    output logic                    res_cout,
    output logic [IDW-1:0]          res_id,
    output logic                    busy
);

    localparam int NSLICE = nslice(DATA_W, SLICE_W);
    localparam int CNTW   = clog2w(NSLICE);

    generate
        if ((DATA_W % SLICE_W) != 0 || N_REQ < 2) begin : g_bad_cfg
            $error("add_slice_sequencer: DATA_W must be a multiple of SLICE_W and N_REQ >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [IDW-1:0]      last_grant_q, last_grant_d;
    logic [CNTW-1:0]     idx_q, idx_d;
    logic                carry_q, carry_d;
    logic                cout_q, cout_d;
    logic                res_valid_q, res_valid_d;
    logic                busy_q, busy_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [N_REQ-1:0]    gnt;
    logic [IDW-1:0]      gnt_idx;
    logic                gnt_vld;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (gnt),
        .grant_idx  (gnt_idx),
        .grant_vld  (gnt_vld)
    );

    // ------------------------------------------------------------------
    // The one shared slice adder
    // ------------------------------------------------------------------
    logic [SLICE_W-1:0]  slice_a;
    logic [SLICE_W-1:0]  slice_b;
    logic [SLICE_W:0]    slice_full;

    always_comb begin
        slice_a    = a_q[idx_q*SLICE_W +: SLICE_W];
        slice_b    = b_q[idx_q*SLICE_W +: SLICE_W];
        slice_full = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE_W{1'b0}}, carry_q};
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        cout_d       = cout_q;
        res_valid_d  = res_valid_q;
        req_ready    = '0;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    // Grant is combinational and only lasts this one cycle;
                    // operands are captured on the same edge.
                    req_ready = gnt;
                    a_d       = req_a[gnt_idx*DATA_W +: DATA_W];
                    b_d       = req_b[gnt_idx*DATA_W +: DATA_W];
                    id_d      = gnt_idx;
                    sum_d     = '0;
                    cout_d    = 1'b0;
                    carry_d   = 1'b0;
                    idx_d     = '0;
                    state_d   = RUN;
                end
            end

            RUN: begin
                sum_d[idx_q*SLICE_W +: SLICE_W] = slice_full[SLICE_W-1:0];
                carry_d = slice_full[SLICE_W];
                idx_d   = idx_q + 1'b1;
                if (idx_q == CNTW'(NSLICE - 1)) begin
                    idx_d       = '0;
                    cout_d      = slice_full[SLICE_W];
                    res_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef ADD_SEQ_SATURATE_EN
                    if (slice_full[SLICE_W]) begin
                        sum_d = '1;
                    end
`endif
                end
            end

            DONE: begin
                if (res_ready) begin
                    // Rotation point only moves once the result is delivered.
                    res_valid_d  = 1'b0;
                    last_grant_d = id_q;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            id_q         <= '0;
            last_grant_q <= IDW'(N_REQ - 1);
            idx_q        <= '0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            cout_q       <= cout_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_add_slice_sequencer.sv
// Scoreboard bench for add_slice_sequencer: a predictor issues expected
// results from a round-robin / integer-add model, a monitor checks them.
module tb_add_slice_sequencer;

    localparam int N   = 4;
    localparam int W   = 12;
    localparam int NS  = 4;
    localparam int LAT = NS + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic            res_valid;
    logic            res_ready;
    logic [W-1:0]    res_sum;
    logic            res_cout;
    logic [1:0]      res_id;
    logic            busy;

    add_slice_sequencer #(.N_REQ(N), .DATA_W(W), .SLICE_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Driver-side operand storage, packed onto the DUT buses.
    logic [W-1:0] da [N];
    logic [W-1:0] db [N];
    logic [N-1:0] dv;
    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_a[g*W +: W] = da[g];
        assign req_b[g*W +: W] = db[g];
    end
    assign req_valid = dv;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           id;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];

    function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] s, output logic c);
        logic [W:0] t;
        t = {1'b0, a} + {1'b0, b};
        s = t[W-1:0];
        c = t[W];
`ifdef ADD_SEQ_SATURATE_EN
        if (c) s = '1;
`endif
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    int  m_last    = N - 1;
    bit  m_busy    = 1'b0;
    int  m_acc_cyc = 0;
    bit  hs_pend   = 1'b0;
    int  hs_cyc    = 0;

    // Predictor: decides when the model accepts and what the answer must be.
    always @(negedge clk) begin
        if (rst) begin
            m_last  = N - 1;
            m_busy  = 1'b0;
            hs_pend = 1'b0;
        end else begin
            if (hs_pend && cyc > hs_cyc) begin
                m_busy  = 1'b0;
                hs_pend = 1'b0;
            end
            chk("busy", busy, (m_busy && cyc > m_acc_cyc));
            if (!m_busy && req_valid != '0) begin
                int   w;
                exp_t e;
                w = rr_pick(req_valid, m_last);
                chk("req_ready_grant", req_ready, 64'(1 << w));
                ref_add(req_a[w*W +: W], req_b[w*W +: W], e.sum, e.cout);
                e.id  = w;
                e.due = cyc + LAT;
                sb.push_back(e);
                grant_log.push_back(w);
                m_last    = w;
                m_busy    = 1'b1;
                m_acc_cyc = cyc;
            end else begin
                chk("req_ready_idle", req_ready, 0);
            end
        end
    end

    // Monitor: checks every presented result against the scoreboard head.
    bit           seen     = 1'b0;
    bit           late_rep = 1'b0;
    logic [W-1:0] last_sum;
    logic         last_cout;
    int           last_id;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            seen     = 1'b0;
            late_rep = 1'b0;
        end else if (res_valid) begin
            if (sb.size() == 0) begin
                chk("res_unexpected", res_valid, 0);
            end else begin
                if (!seen) begin
                    chk("latency", cyc, sb[0].due);
                    seen = 1'b1;
                end
                chk("res_sum", res_sum, sb[0].sum);
                chk("res_cout", res_cout, sb[0].cout);
                chk("res_id", res_id, sb[0].id);
                if (res_ready) begin
                    last_sum  = res_sum;
                    last_cout = res_cout;
                    last_id   = int'(res_id);
                    void'(sb.pop_front());
                    seen     = 1'b0;
                    late_rep = 1'b0;
                    hs_pend  = 1'b1;
                    hs_cyc   = cyc;
                end
            end
        end else if (sb.size() != 0 && !seen && cyc > sb[0].due && !late_rep) begin
            chk("latency_late", res_valid, 1);
            late_rep = 1'b1;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_grant(input int i);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk); #1;
            if (req_ready[i]) ok = 1'b1;
        end
        chk("grant_wait", ok, 1);
        @(posedge clk); #1;
        dv[i] = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 80 && !ok; k++) begin
            @(negedge clk); #2;
            if (sb.size() == 0 && !m_busy && !hs_pend) ok = 1'b1;
        end
        chk("drain", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        da[i] = a;
        db[i] = b;
        dv[i] = 1'b1;
        wait_grant(i);
        drain();
    endtask

    task automatic do_reset();
        dv = '0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [W-1:0] sat_exp;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] g;
        bit           ok;

        dv        = '0;
        res_ready = 1'b1;
        rst       = 1'b1;
        for (int i = 0; i < N; i++) begin
            da[i] = '0;
            db[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_res_cout", res_cout, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1. basic add from requester 0
        do_op(0, 12'h5A3, 12'h0FF);
        chk("t1_sum", last_sum, 12'h6A2);
        chk("t1_cout", last_cout, 0);
        chk("t1_id", last_id, 0);

        // 2. carry ripples across slices
        do_op(0, 12'h1FF, 12'h001);
        chk("t2_sum", last_sum, 12'h200);
        chk("t2_cout", last_cout, 0);

        // 3. overflow out of the MSB slice
        do_op(0, 12'hFFF, 12'h001);
`ifdef ADD_SEQ_SATURATE_EN
        sat_exp = 12'hFFF;
`else
        sat_exp = 12'h000;
`endif
        chk("t3_sum", last_sum, sat_exp);
        chk("t3_cout", last_cout, 1);

        // 4. all requesters held high from reset: order 0,1,2,3,0
        do_reset();
        grant_log.delete();
        for (int i = 0; i < N; i++) begin
            da[i] = W'($urandom);
            db[i] = W'($urandom);
        end
        dv = '1;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk); #1;
            g = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    da[i] = W'($urandom);
                    db[i] = W'($urandom);
                end
            end
            if (grant_log.size() >= 5) ok = 1'b1;
        end
        dv = '0;
        chk("t4_grants_seen", ok, 1);
        drain();
        if (grant_log.size() >= 5) begin
            chk("t4_order0", grant_log[0], 0);
            chk("t4_order1", grant_log[1], 1);
            chk("t4_order2", grant_log[2], 2);
            chk("t4_order3", grant_log[3], 3);
            chk("t4_order4", grant_log[4], 0);
        end

        // 5. backpressure in DONE, competing requester must wait
        res_ready = 1'b0;
        da[2] = 12'h3C5; db[2] = 12'h44A;
        da[3] = 12'h800; db[3] = 12'h801;
        dv    = 4'b1100;
        wait_grant(2);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk); #1;
            if (res_valid) ok = 1'b1;
        end
        chk("t5_valid_seen", ok, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_grant(3);
        drain();
        chk("t5_last_id", last_id, 3);

        // 6. reset in the middle of RUN (slice 2)
        da[1] = 12'hABC; db[1] = 12'h777;
        dv[1] = 1'b1;
        wait_grant(1);
        @(posedge clk);
        @(posedge clk); #3;
        chk("t6_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_res_valid", res_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_res_sum", res_sum, 0);
        chk("t6_res_cout", res_cout, 0);
        chk("t6_res_id", res_id, 0);
        chk("t6_req_ready", req_ready, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(1, 12'h007, 12'h001);
        chk("t6_sum", last_sum, 12'h008);
        chk("t6_cout", last_cout, 0);
        chk("t6_id", last_id, 1);

        // 7. random traffic with random backpressure and request drops
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            g = req_ready;
            @(posedge clk); #1;
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (g[i] || !dv[i]) begin
                    dv[i] = ($urandom_range(0, 2) != 0);
                    da[i] = ($urandom_range(0, 4) == 0) ? 12'hFFF : W'($urandom);
                    db[i] = ($urandom_range(0, 4) == 0) ? 12'h001 : W'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    dv[i] = 1'b0;
                end
            end
        end
        dv        = '0;
        res_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
